// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: armed rising-level-crossing capture of DEPTH=2^AW samples into a buffer with a registered read port.
// Define ADC_CAP_AUTO_TRIG_EN to force a trigger after TIMEOUT cycles spent armed.
module adc_capture_ctrl #(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_arm,
    input  logic          i_abort,
    input  logic [DW-1:0] i_din,
    input  logic          i_otr_in,
    input  logic [DW-1:0] i_trig_lvl,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic [1:0]    o_state,
    output logic          o_done,
    output logic          o_otr_flag,
    output logic          o_auto_flag
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;
    state_t        r_state, w_next;
    logic [DW-1:0] r_prev, r_rd_data;
    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wptr, w_waddr;
    logic          r_otr, r_auto, w_cross, w_force, w_trig, w_we, w_arm_go;

    assign w_cross  = r_prev < i_trig_lvl && i_din >= i_trig_lvl;
    assign w_trig   = r_state == S_ARMED && (w_cross || w_force);
    assign w_we     = !i_abort && (w_trig || r_state == S_CAPTURE);
    assign w_arm_go = !i_abort && i_arm && (r_state == S_IDLE || r_state == S_DONE);
    assign w_waddr  = r_state == S_ARMED ? '0 : r_wptr;

`ifdef ADC_CAP_AUTO_TRIG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst || w_arm_go)
            r_cnt <= '0;
        else if (r_state == S_ARMED)
            r_cnt <= r_cnt + 1'b1;
    end
    assign w_force = r_cnt == CW'(TIMEOUT - 1);
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = i_arm ? S_ARMED : r_state;
            S_ARMED:        w_next = w_trig ? S_CAPTURE : S_ARMED;
            S_CAPTURE:      w_next = &r_wptr ? S_DONE : S_CAPTURE;
            default:        w_next = S_IDLE;
        endcase
        if (i_abort)
            w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_prev    <= '1;
            r_wptr    <= '0;
            r_otr     <= 1'b0;
            r_auto    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_next;
            r_prev    <= i_din;
            r_rd_data <= r_mem[i_rd_addr];
            if (w_we)
                r_wptr <= w_waddr + 1'b1;
            r_otr  <= w_arm_go ? 1'b0 : r_otr | (w_we & i_otr_in);
            // a genuine crossing in the timeout cycle is a normal trigger
            r_auto <= w_arm_go ? 1'b0 : r_auto | (w_trig & w_force & !w_cross & !i_abort);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we)
            r_mem[w_waddr] <= i_din;
    end

    assign o_rd_data   = r_rd_data;
    assign o_state     = r_state;
    assign o_done      = r_state == S_DONE;
    assign o_otr_flag  = r_otr;
    assign o_auto_flag = r_auto;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed scoreboard bench; read expectations are queued by stimulus and popped by a monitor.
module tb_adc_capture_ctrl;
    logic       clk = 1'b0;
    logic       rst, arm, abort, otr_in;
    logic [7:0] din, trig_lvl, rd_addr, rd_data;
    logic [1:0] state;
    logic       done, otr_flag, auto_flag;
    logic       rd_req = 1'b0, rv_d = 1'b0;
    int         checks = 0, failures = 0, mon_e, old5;
    int         exp_q[$];

    always #5 clk = ~clk;

    adc_capture_ctrl #(.DW(8), .AW(8), .TIMEOUT(1000)) dut (
        .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_abort(abort), .i_din(din),
        .i_otr_in(otr_in), .i_trig_lvl(trig_lvl), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_state(state), .o_done(done),
        .o_otr_flag(otr_flag), .o_auto_flag(auto_flag)
    );

    always @(posedge clk) rv_d <= rd_req;

    always @(negedge clk) begin
        if (rv_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_data: got %0d with no expected value queued", rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(rd_data) != mon_e) begin
                    failures++;
                    $display("FAIL rd_data: got %0d expected %0d", rd_data, mon_e);
                end
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        rd_req = 1'b0;
        arm    = 1'b0;
        abort  = 1'b0;
        otr_in = 1'b0;
    endtask

    task automatic rd(input int a, input int e);
        rd_addr = a[7:0];
        rd_req  = 1'b1;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; otr_in = 1'b0;
        din = 8'd0; trig_lvl = 8'd100; rd_addr = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_otr", int'(otr_flag), 0);
        chk("rst_auto", int'(auto_flag), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        // ramp capture, trigger at 100; ARM mid-capture must be ignored
        for (int i = 0; i <= 356; i++) begin
            cyc();
            if (i == 100) chk("ramp_armed", int'(state), 1);
            if (i == 101) chk("ramp_capture", int'(state), 2);
            if (i == 355) chk("ramp_not_done_yet", int'(state), 2);
            if (i == 356) chk("ramp_done_state", int'(state), 3);
            if (i == 356) chk("ramp_done_flag", int'(done), 1);
            din = i[7:0];
            arm = (i == 0 || i == 200);
        end
        cyc();
        chk("ramp_otr", int'(otr_flag), 0);
        chk("ramp_auto", int'(auto_flag), 0);
        for (int a = 0; a < 256; a++) begin
            cyc();
            rd(a, (100 + a) & 255);
        end
        // re-arm from DONE, one out-of-range sample at capture index 37
        trig_lvl = 8'd50;
        for (int i = 0; i <= 306; i++) begin
            cyc();
            if (i == 1) chk("otr_armed", int'(state), 1);
            if (i == 87) chk("otr_before", int'(otr_flag), 0);
            if (i == 88) chk("otr_after", int'(otr_flag), 1);
            if (i == 305) chk("otr_capture", int'(state), 2);
            if (i == 306) chk("otr_done", int'(state), 3);
            din    = i[7:0];
            arm    = (i == 0);
            otr_in = (i == 87);
        end
        cyc(); chk("otr_held_done", int'(otr_flag), 1); rd(0, 50);
        cyc(); rd(37, 87);
        cyc(); rd(255, 49);
        cyc(); rd(20, 70);
        cyc(); arm = 1'b1; din = 8'd0;
        cyc();
        chk("rearm_state", int'(state), 1);
        chk("rearm_clears_otr", int'(otr_flag), 0);
        // step-3 ramp, abort at capture index 20
        trig_lvl = 8'd10;
        for (int i = 0; i <= 25; i++) begin
            cyc();
            if (i == 4) chk("abort_pre_trig", int'(state), 1);
            if (i == 5) chk("abort_capture", int'(state), 2);
            if (i == 25) chk("abort_idle", int'(state), 0);
            din    = 8'((3 * i) & 255);
            otr_in = (i == 9);
            abort  = (i == 24);
        end
        cyc(); chk("abort_keeps_otr", int'(otr_flag), 1); rd(0, 12);
        cyc(); rd(19, 69);
        cyc(); rd(20, 70);
        cyc(); rd(21, 71);
        cyc(); rd(5, 27);
        // ARM together with ABORT in IDLE
        cyc(); arm = 1'b1; abort = 1'b1;
        cyc(); chk("arm_abort_idle", int'(state), 0);
        // constant input above threshold: no crossing
        din = 8'd150; trig_lvl = 8'd100;
        cyc(); arm = 1'b1;
`ifdef ADC_CAP_AUTO_TRIG_EN
        for (int j = 0; j <= 1255; j++) begin
            cyc();
            if (j == 999) chk("auto_still_armed", int'(state), 1);
            if (j == 1000) chk("auto_forced", int'(state), 2);
        end
        chk("auto_done", int'(state), 3);
        chk("auto_flag_set", int'(auto_flag), 1);
        rd(0, 150);
        cyc(); rd(128, 150);
        cyc(); rd(255, 150);
        old5 = 150;
`else
        repeat (50) cyc();
        chk("hold_armed", int'(state), 1);
        chk("hold_auto", int'(auto_flag), 0);
        old5 = 27;
`endif
        cyc(); abort = 1'b1;
        cyc(); chk("hold_abort", int'(state), 0);
        // read and write of address 5 in the same cycle
        trig_lvl = 8'd10; din = 8'd0;
        for (int i = 0; i <= 17; i++) begin
            cyc();
            if (i == 12) chk("rw_auto_clear", int'(auto_flag), 0);
            din = i[7:0];
            arm = (i == 0);
            if (i == 15) rd(5, old5);
            if (i == 16) rd(5, 15);
        end
        repeat (3) cyc();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Triggered-capture sequencer for the ADC receive path. It sits after the ADC interface's registered 8-bit sample and out-of-range flag. When armed, it waits for a rising level crossing, then writes a fixed-length block of consecutive samples into an internal buffer. The buffer is read back on a random-access port by the downstream processing or DAC playback logic.

## Interface
- DW, 8, sample width in bits
- AW, 8, buffer address width; DEPTH = 2^AW samples
- TIMEOUT, 1000, auto-trigger timeout in cycles (used only with ADC_CAP_AUTO_TRIG_EN)

- CLK  in  1  system/ADC sample clock; all logic on its rising edge
- RST  in  1  reset; synchronous, active-high
- ARM  in  1  request a new capture; single-cycle pulse or level
- ABORT  in  1  cancel the capture in progress
- DIN  in  DW  unsigned ADC sample, one per cycle
- OTR_IN  in  1  ADC out-of-range flag, aligned with DIN
- TRIG_LVL  in  DW  unsigned trigger threshold
- RD_ADDR  in  AW  buffer read address
- RD_DATA  out  DW  buffer read data, registered
- STATE  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE
- DONE  out  1  high while STATE==DONE
- OTR_FLAG  out  1  sticky: at least one written sample had OTR_IN=1
- AUTO_FLAG  out  1  sticky: the current capture was force-triggered

## Operation
- PREV is a DW-bit register loaded with DIN every cycle. It resets to all ones so that no false crossing occurs just after reset.
- Trigger condition (evaluated only in ARMED): PREV < TRIG_LVL and DIN >= TRIG_LVL, unsigned compare.
- IDLE: ARM=1 → ARMED. On the same transition, OTR_FLAG and AUTO_FLAG are cleared.
- ARMED: on trigger, DIN is written to address 0, WPTR is set to 1, and the state moves to CAPTURE. ARM is ignored in this state.
- CAPTURE: every cycle DIN is written at WPTR and WPTR increments. When the write at address DEPTH-1 occurs, the state moves to DONE. ARM is ignored in this state.
- DONE: holds indefinitely. ARM=1 → ARMED, which clears both flags; the old buffer data stays until it is overwritten.
- ABORT=1 in any state: the state moves to IDLE on the next edge and no write occurs that cycle. ABORT has priority over ARM, trigger and the last write. Buffer contents and flags are retained.
- OTR_FLAG is set on any buffer write cycle with OTR_IN=1.
- Read port:
  - RD_DATA is loaded from buffer[RD_ADDR] each cycle.
  - Reads are legal in every state.
  - A read and a write to the same address in the same cycle returns the old data.
- WPTR wraps only via the state transition; it never writes beyond DEPTH-1.

## Timing
- Reset values:
  - STATE=IDLE; DONE=0; OTR_FLAG=0; AUTO_FLAG=0; RD_DATA=0; WPTR=0; PREV=all ones.
  - Buffer contents are undefined after reset.
- Arming: ARM sampled at edge t → STATE=ARMED from t+1. Trigger evaluation starts in the cycle after the ARM edge.
- Capture sequence: trigger true in cycle c → addr 0 written at edge c. Addr k is written at edge c+k. STATE=CAPTURE from c+1 and STATE=DONE (DONE=1) from c+DEPTH.
- Total capture is exactly DEPTH consecutive samples, with the trigger sample at address 0.
- Read latency: RD_ADDR at edge t → RD_DATA valid after edge t+1 (1 cycle).
- ARM asserted with ABORT in the same cycle → IDLE (ABORT wins).
- RST has priority over everything, including mid-capture.

## Configuration
- ADC_CAP_AUTO_TRIG_EN defined:
  - A counter clears when ARMED is entered and increments every cycle spent in ARMED.
  - If no crossing has occurred when the counter reaches TIMEOUT-1, a trigger is forced in that cycle and AUTO_FLAG is set.
  - A real crossing in the same cycle counts as a normal trigger (AUTO_FLAG stays 0).
- Not defined: no counter is built, AUTO_FLAG is tied to 0, and ARMED waits indefinitely.

## Test plan
- Reset, then ramp DIN 0..255 with TRIG_LVL=100 and ARM pulse → trigger on DIN=100; buffer[0..255] = 100..255, 0..99 (ramp wraps); DONE high 256 cycles after trigger; OTR_FLAG=0.
- DIN held at 150, TRIG_LVL=100, ARM → no trigger; STATE stays ARMED (macro off). With macro on and TIMEOUT=1000 → forced trigger 1000 cycles after entering ARMED; AUTO_FLAG=1; buffer all 150.
- OTR_IN=1 for one cycle at capture sample 37 → OTR_FLAG=1 at DONE; a new ARM clears it.
- ABORT at capture sample 20 → STATE=IDLE next cycle; buffer[0..19] written, buffer[20] unchanged.
- ARM and ABORT together in IDLE → STATE stays IDLE. ARM during CAPTURE → ignored; DONE timing unchanged.
- Read addr 5 while writing addr 5 → RD_DATA shows the old value next cycle and the new value one cycle later.
